// File: rtl/satatrn_txmux.sv
// satatrn_txmux: packet-atomic FIS mux merging register channels and a gated,
// auto-split DATA payload source into one 32-bit stream toward the link layer.
module satatrn_txmux #(
  parameter int NREG = 2,
  parameter int LGMAXDATA = 11,
  parameter bit OPT_RR = 1'b1,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic                i_phy_clk,
  input  logic                i_phy_reset_n,
  input  logic [NREG-1:0]     i_reg_valid,
  output logic [NREG-1:0]     o_reg_ready,
  input  logic [32*NREG-1:0]  i_reg_data,
  input  logic [NREG-1:0]     i_reg_last,
  input  logic                i_txgate,
  input  logic                i_data_valid,
  output logic                o_data_ready,
  input  logic [31:0]         i_data_data,
  input  logic                i_data_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_data,
  output logic                o_last,
  output logic                o_busy
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_REG = 2'd1, S_DATA = 2'd2;
  logic [1:0] state, nstate, gsync;
  logic [IW-1:0] sel, rr, win, cur;
  logic [IW:0] j;
  logic found, free, data_win, take, rlast, dend, nlast;
  logic [31:0] rdata, ndata;
  logic [LGMAXDATA-1:0] cnt;
  assign free = !o_valid || i_ready;
  assign data_win = gsync[1] && i_data_valid;
  assign o_busy = state != S_IDLE;
  assign o_data_ready = state == S_DATA && free;
  assign cur = state == S_REG ? sel : win;
  assign rdata = i_reg_data[{cur, 5'd0} +: 32];
  assign rlast = i_reg_last[cur];
  // a full-size FIS is closed on the last counter value even without i_data_last
  assign dend = i_data_last || &cnt;
  // scan from the lowest priority upward so the highest-priority candidate is assigned last
  always_comb begin
    win = '0;
    found = 1'b0;
    j = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      j = OPT_RR ? {1'b0, rr} + (IW+1)'(i) : (IW+1)'(i);
      j = j >= (IW+1)'(NREG) ? j - (IW+1)'(NREG) : j;
      if (i_reg_valid[j[IW-1:0]]) begin
        win = j[IW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    o_reg_ready = '0;
    if (free && (state == S_REG || (state == S_IDLE && !data_win && found))) o_reg_ready[cur] = 1'b1;
  end
  assign take = state == S_IDLE ? (data_win || found) : state == S_REG ? i_reg_valid[sel] : i_data_valid;
  assign ndata = state == S_DATA ? i_data_data : (state == S_IDLE && data_win) ? 32'h0000_0046 : rdata;
  assign nlast = state == S_DATA ? dend : !(state == S_IDLE && data_win) && rlast;
  assign nstate = state == S_IDLE ? (data_win ? S_DATA : (found && !rlast) ? S_REG : S_IDLE) :
                  !take ? state :
                  state == S_REG ? (rlast ? S_IDLE : S_REG) : (dend ? S_IDLE : S_DATA);
  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
    if (!i_phy_reset_n) begin
      gsync <= '0;
      state <= S_IDLE;
      sel <= '0;
      rr <= '0;
      cnt <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
    end else begin
      gsync <= {gsync[0], i_txgate};
      if (free) begin
        state <= nstate;
        o_valid <= take;
        if (take || OPT_LOWPOWER) begin
          o_data <= take ? ndata : '0;
          o_last <= take && nlast;
        end
        if (state == S_IDLE && data_win) cnt <= '0;
        else if (state == S_DATA && take) cnt <= cnt + 1'b1;
        if (state == S_IDLE && !data_win && found) begin
          sel <= win;
          if (OPT_RR) rr <= win == IW'(NREG - 1) ? '0 : win + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_satatrn_txmux.sv
// tb_satatrn_txmux: scoreboard bench for the transport TX mux; expected words
// are queued as sources hand them over and popped as the link side accepts them.
module tb_satatrn_txmux;
  localparam int NREG = 2, LG = 2, MAXW = 1 << LG;
  logic clk = 0, rst_n = 0, bp = 0;
  always #5 clk = ~clk;
  logic [NREG-1:0] i_reg_valid = '0, i_reg_last = '0, o_reg_ready, fp_reg_ready;
  logic [32*NREG-1:0] i_reg_data = '0;
  logic i_txgate = 0, i_data_valid = 0, i_data_last = 0, i_ready = 1;
  logic [31:0] i_data_data = '0, o_data, fp_data;
  logic o_data_ready, o_valid, o_last, o_busy, fp_data_ready, fp_valid, fp_last, fp_busy;
  int checks = 0, failures = 0;
  logic [32:0] q[$];
  logic sp = 0;
  logic [32:0] pw = '0;

  satatrn_txmux #(.NREG(NREG), .LGMAXDATA(LG), .OPT_RR(1'b1), .OPT_LOWPOWER(1'b0)) dut (
    .i_phy_clk(clk), .i_phy_reset_n(rst_n), .i_reg_valid(i_reg_valid), .o_reg_ready(o_reg_ready),
    .i_reg_data(i_reg_data), .i_reg_last(i_reg_last), .i_txgate(i_txgate), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .i_data_data(i_data_data), .i_data_last(i_data_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_last(o_last), .o_busy(o_busy));

  satatrn_txmux #(.NREG(NREG), .LGMAXDATA(LG), .OPT_RR(1'b0), .OPT_LOWPOWER(1'b0)) dut_fp (
    .i_phy_clk(clk), .i_phy_reset_n(rst_n), .i_reg_valid(i_reg_valid), .o_reg_ready(fp_reg_ready),
    .i_reg_data(i_reg_data), .i_reg_last(i_reg_last), .i_txgate(i_txgate), .i_data_valid(i_data_valid),
    .o_data_ready(fp_data_ready), .i_data_data(i_data_data), .i_data_last(i_data_last), .o_valid(fp_valid),
    .i_ready(i_ready), .o_data(fp_data), .o_last(fp_last), .o_busy(fp_busy));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // link-side monitor: pops the scoreboard on every accepted word, checks stall behaviour
  always @(negedge clk) begin
    if (sp) check("stall_hold", {o_valid, o_last, o_data}, {1'b1, pw});
    if (o_valid && !i_ready) check("stall_ready", {o_reg_ready, o_data_ready}, '0);
    if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL extra_word observed=%h expected=none", {o_last, o_data});
      end else check("word", {o_last, o_data}, q.pop_front());
    end
    sp = o_valid && !i_ready;
    pw = {o_last, o_data};
  end

  task automatic send_reg(input int ch, input int n, input logic [31:0] base);
    int i = 0, cyc = 0;
    logic rdy, lf = 0;
    logic [32:0] lw = '0;
    while (i < n && cyc < 300) begin
      i_reg_valid[ch] = 1'b1;
      i_reg_data[32*ch +: 32] = base + i;
      i_reg_last[ch] = (i == n - 1);
      @(negedge clk);
      if (lf) check("reg_latency", {o_valid, o_last, o_data}, {1'b1, lw});
      rdy = o_reg_ready[ch];
      lw = {i == n - 1, base + i};
      if (rdy) q.push_back(lw);
      @(posedge clk);
      #1;
      lf = rdy && !bp;
      if (rdy) i++;
      cyc++;
    end
    i_reg_valid[ch] = 1'b0;
    i_reg_last[ch] = 1'b0;
    check("reg_timeout", i, n);
  endtask

  task automatic send_data(input int n, input int abort_at, input logic [31:0] base);
    int i = 0, cyc = 0;
    logic rdy, lf = 0;
    logic [32:0] lw = '0;
    q.push_back({1'b0, 32'h0000_0046});
    while (i < n && i != abort_at && cyc < 400) begin
      i_data_valid = 1'b1;
      i_data_data = base + i;
      i_data_last = (i == n - 1);
      @(negedge clk);
      if (lf) check("data_latency", {o_valid, o_last, o_data}, {1'b1, lw});
      rdy = o_data_ready;
      lw = {(i == n - 1) || (i % MAXW == MAXW - 1), base + i};
      if (rdy) begin
        q.push_back(lw);
        if (i % MAXW == MAXW - 1 && i != n - 1) q.push_back({1'b0, 32'h0000_0046});
      end
      @(posedge clk);
      #1;
      lf = rdy && !bp;
      if (rdy) i++;
      cyc++;
    end
    i_data_valid = 1'b0;
    i_data_last = 1'b0;
    check("data_timeout", i, abort_at >= 0 ? abort_at : n);
  endtask

  task automatic run_rr(input int n);
    int g = 0, cyc = 0, prev = -1, n0 = 0, n1 = 0;
    logic [NREG-1:0] r;
    i_reg_valid = '1;
    i_reg_last = '1;
    while (g < n && cyc < 100) begin
      i_reg_data = {32'h200 + n1, 32'h100 + n0};
      @(negedge clk);
      r = o_reg_ready;
      if (fp_valid) check("fixed_prio", fp_data[31:8], 24'h000001);
      if (r[0]) q.push_back({1'b1, 32'h100 + n0});
      if (r[1]) q.push_back({1'b1, 32'h200 + n1});
      if (r != '0) begin
        check("rr_onehot", $countones(r), 1);
        if (prev >= 0) check("rr_alt", r[1], prev == 0);
        prev = int'(r[1]);
        g++;
      end
      @(posedge clk);
      #1;
      if (r[0]) n0++;
      if (r[1]) n1++;
      cyc++;
    end
    i_reg_valid = '0;
    i_reg_last = '0;
    check("rr_timeout", g, n);
  endtask

  task automatic drain();
    int c = 0;
    while (q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain", q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", {o_last, o_data}, 0);
    check("rst_ready", {o_reg_ready, o_data_ready}, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    send_reg(0, 5, 32'h11);
    send_reg(1, 3, 32'h2000_0000);
    repeat (2) @(posedge clk);
    #1;
    run_rr(8);
    repeat (3) @(posedge clk);
    #1;
    i_txgate = 0;
    i_data_valid = 1;
    i_data_data = 32'hDEAD_0000;
    repeat (6) begin
      @(negedge clk);
      check("gate_ready", o_data_ready, 0);
      check("gate_valid", o_valid, 0);
    end
    @(posedge clk);
    #1;
    i_data_valid = 0;
    i_txgate = 1;
    repeat (3) @(posedge clk);
    #1;
    send_data(3, -1, 32'hA0A0_0000);
    send_data(6, -1, 32'hB000_0000);
    drain();
    bp = 1;
    send_reg(1, 6, 32'hC000_0000);
    send_data(5, -1, 32'hC100_0000);
    send_reg(0, 3, 32'hC200_0000);
    send_data(9, -1, 32'hC300_0000);
    drain();
    bp = 0;
    @(posedge clk);
    #1;
    send_data(8, 3, 32'hE000_0000);
    check("pre_reset_busy", o_busy, 1);
    #2 rst_n = 0;
    #1;
    check("areset_valid", o_valid, 0);
    check("areset_busy", o_busy, 0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    send_data(2, -1, 32'hF000_0000);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
